// File: rtl/rv_pkg.sv
// Shared RV32 field positions, decoded-instruction struct and decode helper
// for the fetch/decode front end.
package rv_pkg;

  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;
  localparam int RD_LSB  = 7;
  localparam int RD_MSB  = 11;
  localparam int FN3_LSB = 12;
  localparam int FN3_MSB = 14;
  localparam int RS1_LSB = 15;
  localparam int RS1_MSB = 19;
  localparam int RS2_LSB = 20;
  localparam int RS2_MSB = 24;
  localparam int FN7_LSB = 25;
  localparam int FN7_MSB = 31;

  localparam logic [1:0] OPC_LOW = 2'b11;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] fn3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] fn7;
    logic       illegal;
  } decoded_t;

  // Only 16 and 32 registers are legal, so range is just bit 4 for RV32E.
  function automatic logic reg_in_range(input logic [4:0] r, input int nreg);
    return (nreg == 32) || (r[4] == 1'b0);
  endfunction

  function automatic decoded_t decode(input logic [31:0] instr, input int nreg);
    decoded_t d;
    d.opcode  = instr[OPC_MSB:OPC_LSB];
    d.rd      = instr[RD_MSB:RD_LSB];
    d.fn3     = instr[FN3_MSB:FN3_LSB];
    d.rs1     = instr[RS1_MSB:RS1_LSB];
    d.rs2     = instr[RS2_MSB:RS2_LSB];
    d.fn7     = instr[FN7_MSB:FN7_LSB];
    d.illegal = (d.opcode[1:0] != OPC_LOW) ||
                !reg_in_range(d.rd, nreg) ||
                !reg_in_range(d.rs1, nreg) ||
                !reg_in_range(d.rs2, nreg);
    return d;
  endfunction

endpackage

// File: rtl/rv_regfile.sv
// Register file with two combinational read ports and one write port;
// x0 and out-of-range registers read zero, and same-cycle writes are bypassed.
module rv_regfile
  import rv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] regs [NREG];
  logic            wb_ok;

  assign wb_ok = wb_en && (wb_addr != 5'd0) && reg_in_range(wb_addr, NREG);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_ok) begin
      regs[wb_addr[AW-1:0]] <= wb_data;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [4:0] a);
    if (a == 5'd0 || !reg_in_range(a, NREG)) return '0;
    if (wb_en && wb_addr == a) return wb_data;
    return regs[a[AW-1:0]];
  endfunction

  always_comb begin
    rdata1 = read_port(rs1);
    rdata2 = read_port(rs2);
  end

endmodule

// File: rtl/rv_fetch_decode.sv
// Two-stage front end: fetch from a loadable instruction memory, then decode
// and read the register file into a valid/ready output register.
module rv_fetch_decode
  import rv_pkg::*;
#(
  parameter  int XLEN       = 32,
  parameter  int IMEM_DEPTH = 32,
  parameter  int NREG       = 32,
  parameter  int RESET_PC   = 0,
  localparam int PC_W       = $clog2(IMEM_DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            imem_we,
  input  logic [PC_W-1:0] imem_waddr,
  input  logic [31:0]     imem_wdata,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_fn3,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [6:0]      out_fn7,
  output logic [XLEN-1:0] out_rdata1,
  output logic [XLEN-1:0] out_rdata2,
  output logic            out_illegal
);

  logic [31:0]     imem [IMEM_DEPTH];
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] f_pc;
  logic [31:0]     f_instr;
  logic            f_valid;
  logic            adv1;
  logic            adv2;
  decoded_t        f_dec;
  decoded_t        out_dec;
  logic [4:0]      rd_addr1;
  logic [4:0]      rd_addr2;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;

  assign adv2  = !out_valid || out_ready;
  assign adv1  = adv2 || !f_valid;
  assign f_dec = decode(f_instr, NREG);

  // Registered read gives read-before-write on a same-address write.
  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_waddr] <= imem_wdata;
    if (adv1) f_instr <= imem[pc];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= PC_W'(RESET_PC);
      f_pc      <= '0;
      f_valid   <= 1'b0;
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_instr <= '0;
      out_dec   <= '0;
    end else if (redirect_valid) begin
      pc        <= redirect_pc;
      f_valid   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (adv1) begin
        f_pc    <= pc;
        f_valid <= 1'b1;
        pc      <= pc + PC_W'(1);
      end
      if (adv2) begin
        out_valid <= f_valid;
        out_pc    <= f_pc;
        out_instr <= f_instr;
        out_dec   <= f_dec;
      end
    end
  end

  // While stalled, keep reading the held operands so writebacks reach them.
  assign rd_addr1 = adv2 ? f_dec.rs1 : out_dec.rs1;
  assign rd_addr2 = adv2 ? f_dec.rs2 : out_dec.rs2;

  rv_regfile #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .rs1     (rd_addr1),
    .rs2     (rd_addr2),
    .rdata1  (rdata1),
    .rdata2  (rdata2)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out_rdata1 <= '0;
      out_rdata2 <= '0;
    end else begin
      out_rdata1 <= rdata1;
      out_rdata2 <= rdata2;
    end
  end

  assign out_opcode  = out_dec.opcode;
  assign out_rd      = out_dec.rd;
  assign out_fn3     = out_dec.fn3;
  assign out_rs1     = out_dec.rs1;
  assign out_rs2     = out_dec.rs2;
  assign out_fn7     = out_dec.fn7;
  assign out_illegal = out_dec.illegal;

endmodule

// File: tb/tb_rv_fetch_decode.sv
// Bench for rv_fetch_decode: a default RV32I instance and an RV32E instance
// (IMEM_DEPTH=8, RESET_PC=6) share stimulus and a stream-level model.
module tb_rv_fetch_decode;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, imem_we, redirect_valid, wb_en, out_ready;
  logic [4:0]  imem_waddr, redirect_pc, wb_addr;
  logic [31:0] imem_wdata, wb_data;

  logic        a_valid, a_illegal;
  logic [4:0]  a_pc, a_rd, a_rs1, a_rs2;
  logic [31:0] a_instr, a_rdata1, a_rdata2;
  logic [6:0]  a_opcode, a_fn7;
  logic [2:0]  a_fn3;

  logic        b_valid, b_illegal;
  logic [2:0]  b_pc;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [31:0] b_instr, b_rdata1, b_rdata2;
  logic [6:0]  b_opcode, b_fn7;
  logic [2:0]  b_fn3;

  rv_fetch_decode #(.XLEN(32), .IMEM_DEPTH(32), .NREG(32), .RESET_PC(0)) dut_a (
    .clk(clk), .reset(reset), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(a_valid),
    .out_ready(out_ready), .out_pc(a_pc), .out_instr(a_instr), .out_opcode(a_opcode),
    .out_rd(a_rd), .out_fn3(a_fn3), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_fn7(a_fn7),
    .out_rdata1(a_rdata1), .out_rdata2(a_rdata2), .out_illegal(a_illegal)
  );

  rv_fetch_decode #(.XLEN(32), .IMEM_DEPTH(8), .NREG(16), .RESET_PC(6)) dut_b (
    .clk(clk), .reset(reset), .imem_we(imem_we), .imem_waddr(imem_waddr[2:0]),
    .imem_wdata(imem_wdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc[2:0]),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(b_valid),
    .out_ready(out_ready), .out_pc(b_pc), .out_instr(b_instr), .out_opcode(b_opcode),
    .out_rd(b_rd), .out_fn3(b_fn3), .out_rs1(b_rs1), .out_rs2(b_rs2), .out_fn7(b_fn7),
    .out_rdata1(b_rdata1), .out_rdata2(b_rdata2), .out_illegal(b_illegal)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  int          depth  [2] = '{32, 8};
  int          nreg   [2] = '{32, 16};
  int          rst_pc [2] = '{0, 6};
  logic [31:0] mimem  [2][32];
  logic [31:0] mreg   [2][32];
  int          exp_pc [2];
  logic        prev_stall [2];
  logic        prev_flush [2];
  bit          started = 0;

  function automatic logic [31:0] mread(input int k, input int r);
    if (r == 0 || r >= nreg[k]) return 32'd0;
    return mreg[k][r];
  endfunction

  function automatic logic millegal(input int k, input logic [31:0] w);
    return (w[1:0] != 2'b11) || (int'(w[11:7]) >= nreg[k]) ||
           (int'(w[19:15]) >= nreg[k]) || (int'(w[24:20]) >= nreg[k]);
  endfunction

  task automatic check_dut(input int k, input logic v, input logic [4:0] pc,
                           input logic [31:0] instr, input logic [6:0] opc,
                           input logic [4:0] rd, input logic [2:0] fn3,
                           input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [6:0] fn7, input logic ill,
                           input logic [31:0] rd1, input logic [31:0] rd2);
    string       p;
    logic [31:0] w;
    p = (k == 0) ? "A" : "B";
    if (prev_flush[k]) chk({p, ".valid_after_flush"}, 32'(v), 32'd0);
    if (prev_stall[k]) chk({p, ".valid_held"}, 32'(v), 32'd1);
    if (v === 1'b1) begin
      w = mimem[k][exp_pc[k]];
      chk({p, ".pc"},      32'(pc),    32'(exp_pc[k]));
      chk({p, ".instr"},   instr,      w);
      chk({p, ".opcode"},  32'(opc),   32'(w[6:0]));
      chk({p, ".rd"},      32'(rd),    32'(w[11:7]));
      chk({p, ".fn3"},     32'(fn3),   32'(w[14:12]));
      chk({p, ".rs1"},     32'(rs1),   32'(w[19:15]));
      chk({p, ".rs2"},     32'(rs2),   32'(w[24:20]));
      chk({p, ".fn7"},     32'(fn7),   32'(w[31:25]));
      chk({p, ".illegal"}, 32'(ill),   32'(millegal(k, w)));
      chk({p, ".rdata1"},  rd1,        mread(k, int'(w[19:15])));
      chk({p, ".rdata2"},  rd2,        mread(k, int'(w[24:20])));
    end
  endtask

  // Check what the last edge produced, then advance the model by the edge to come.
  always @(negedge clk) begin : compare
    logic vld;
    if (started) begin
      check_dut(0, a_valid, a_pc, a_instr, a_opcode, a_rd, a_fn3, a_rs1, a_rs2,
                a_fn7, a_illegal, a_rdata1, a_rdata2);
      check_dut(1, b_valid, {2'b00, b_pc}, b_instr, b_opcode, b_rd, b_fn3, b_rs1,
                b_rs2, b_fn7, b_illegal, b_rdata1, b_rdata2);
    end
    for (int k = 0; k < 2; k++) begin
      vld = (k == 0) ? a_valid : b_valid;
      if (imem_we) mimem[k][int'(imem_waddr) % depth[k]] = imem_wdata;
      prev_flush[k] = reset || redirect_valid;
      prev_stall[k] = !reset && !redirect_valid && (vld === 1'b1) && !out_ready;
      if (reset) begin
        exp_pc[k] = rst_pc[k];
        for (int r = 0; r < 32; r++) mreg[k][r] = 32'd0;
      end else begin
        if (redirect_valid) exp_pc[k] = int'(redirect_pc) % depth[k];
        else if (vld === 1'b1 && out_ready) exp_pc[k] = (exp_pc[k] + 1) % depth[k];
        if (wb_en && wb_addr != 5'd0 && int'(wb_addr) < nreg[k])
          mreg[k][int'(wb_addr)] = wb_data;
      end
    end
    if (reset) started = 1;
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] prog(input int a);
    case (a)
      0:       return 32'h002081B3;   // add x3,x1,x2
      1:       return 32'h402081B3;   // sub x3,x1,x2
      2:       return 32'h0020F1B3;   // and x3,x1,x2
      3:       return 32'h00100233;   // add x4,x0,x1
      4:       return 32'h014082B3;   // add x5,x1,x20
      5:       return 32'h00108133;   // add x2,x1,x1
      6:       return 32'h00000013;   // nop
      7:       return 32'h00000000;   // low opcode bits 00
      default: return 32'h00208033 | (32'(a) << 7);
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
    wb_en   = en;
    wb_addr = addr;
    wb_data = data;
  endtask

  initial begin
    reset = 1'b1; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    wb(1'b0, 5'd0, 32'd0);
    cyc(); cyc();
    // Descending order so the RV32E instance ends up with words 0..7.
    for (int a = 31; a >= 0; a--) begin
      imem_we = 1'b1; imem_waddr = 5'(a); imem_wdata = prog(a);
      cyc();
    end
    imem_we = 1'b0;
    chk("A.reset_valid",  32'(a_valid), 32'd0);
    chk("B.reset_valid",  32'(b_valid), 32'd0);
    chk("A.reset_pc",     32'(a_pc),    32'd0);
    chk("B.reset_instr",  b_instr,      32'd0);
    chk("A.reset_rdata1", a_rdata1,     32'd0);

    reset = 1'b0;
    wb(1'b1, 5'd1, 32'd2);
    cyc();                                    // E1
    wb(1'b1, 5'd2, 32'd3);
    cyc();                                    // E2: first instruction out
    chk("A.lit_valid_c2", 32'(a_valid), 32'd1);
    chk("A.lit_pc_c2",    32'(a_pc),    32'd0);
    chk("A.lit_rd_add",   32'(a_rd),    32'd3);
    chk("A.lit_rs1_add",  32'(a_rs1),   32'd1);
    chk("A.lit_rs2_add",  32'(a_rs2),   32'd2);
    chk("A.lit_rdata1",   a_rdata1,     32'd2);
    chk("A.lit_rdata2",   a_rdata2,     32'd3);
    chk("B.lit_pc_c2",    32'(b_pc),    32'd6);
    wb(1'b0, 5'd0, 32'd0);
    cyc();                                    // E3
    chk("A.lit_pc_c3",    32'(a_pc),    32'd1);
    chk("A.lit_fn7_sub",  32'(a_fn7),   32'h20);
    chk("B.lit_pc_c3",    32'(b_pc),    32'd7);
    chk("B.lit_illegal7", 32'(b_illegal), 32'd1);
    wb(1'b1, 5'd0, 32'h0000FFFF);
    cyc();                                    // E4
    chk("A.lit_pc_c4",    32'(a_pc),    32'd2);
    chk("B.lit_pc_wrap",  32'(b_pc),    32'd0);
    wb(1'b0, 5'd0, 32'd0);
    cyc();                                    // E5
    chk("A.lit_pc_c5",    32'(a_pc),    32'd3);
    chk("A.lit_x0_reads0", a_rdata1,    32'd0);
    chk("B.lit_pc_c5",    32'(b_pc),    32'd1);

    out_ready = 1'b0;                         // backpressure for three edges
    cyc();                                    // E6
    wb(1'b1, 5'd1, 32'h55);
    cyc();                                    // E7
    chk("A.lit_stall_pc",     32'(a_pc),  32'd3);
    chk("A.lit_stall_rdata2", a_rdata2,   32'h55);
    chk("B.lit_stall_rdata1", b_rdata1,   32'h55);
    wb(1'b0, 5'd0, 32'd0);
    cyc();                                    // E8
    chk("B.lit_stall_pc",     32'(b_pc),  32'd1);
    out_ready = 1'b1;
    wb(1'b1, 5'd1, 32'hAB);
    cyc();                                    // E9: bypass into stage-2 load
    chk("A.lit_pc_after_stall", 32'(a_pc), 32'd4);
    chk("A.lit_bypass_rdata1",  a_rdata1,  32'hAB);
    chk("A.lit_x20_legal",      32'(a_illegal), 32'd0);
    chk("B.lit_pc_after_stall", 32'(b_pc), 32'd2);
    wb(1'b0, 5'd0, 32'd0);
    cyc();                                    // E10
    cyc();                                    // E11
    chk("B.lit_pc_x20",      32'(b_pc),      32'd4);
    chk("B.lit_illegal_x20", 32'(b_illegal), 32'd1);
    chk("B.lit_rdata2_x20",  b_rdata2,       32'd0);

    out_ready = 1'b0;
    cyc();                                    // E12: stalled
    redirect_valid = 1'b1; redirect_pc = 5'd5;
    cyc();                                    // E13
    chk("A.lit_redirect_valid", 32'(a_valid), 32'd0);
    chk("B.lit_redirect_valid", 32'(b_valid), 32'd0);
    redirect_valid = 1'b0; out_ready = 1'b1;
    cyc();                                    // E14
    cyc();                                    // E15
    chk("A.lit_redirect_pc", 32'(a_pc), 32'd5);
    chk("B.lit_redirect_pc", 32'(b_pc), 32'd5);
    cyc(); cyc(); cyc();                      // E16..E18
    reset = 1'b1;
    cyc();                                    // E19
    chk("A.lit_midreset_valid", 32'(a_valid), 32'd0);
    chk("B.lit_midreset_valid", 32'(b_valid), 32'd0);
    reset = 1'b0;
    cyc(); cyc();                             // E21
    chk("A.lit_restart_pc",     32'(a_pc),    32'd0);
    chk("B.lit_restart_pc",     32'(b_pc),    32'd6);
    chk("A.lit_restart_rdata1", a_rdata1,     32'd0);

    // Mixed traffic: ready toggling, writebacks and one redirect.
    for (int i = 0; i < 40; i++) begin
      out_ready      = (i % 3) != 0;
      wb((i % 2) == 0, 5'((i * 7) % 32), 32'(i * 32'h1111));
      redirect_valid = (i == 15);
      redirect_pc    = 5'd30;
      cyc();
    end
    redirect_valid = 1'b0;
    wb(1'b0, 5'd0, 32'd0);
    out_ready = 1'b1;
    cyc(); cyc(); cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
